// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bus between the 5-stage datapath and pipeline_ctrl.
//   master : datapath side, drives hazard/branch/memory status, reads controls
//   slave  : controller side, reads status, drives enables/flushes/counters
// clk and rst_n are not part of this bundle.
interface pipeline_ctrl_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] ID_rs1;
  logic [REG_W-1:0] ID_rs2;
  logic             ID_use_rs1;
  logic             ID_use_rs2;
  logic             EX_memread;
  logic [REG_W-1:0] EX_rd;
  logic             EX_branch_taken;
  logic             MEM_memread;
  logic             MEM_memwrite;
  logic             mem_ready;

  logic             mem_req;
  logic             pc_en;
  logic             IF_ID_en;
  logic             ID_EX_en;
  logic             EX_MEM_en;
  logic             MEM_WB_en;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             MEM_WB_bubble;
  logic             mem_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_memread, EX_rd,
           EX_branch_taken, MEM_memread, MEM_memwrite, mem_ready,
    input  mem_req, pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
           IF_ID_flush, ID_EX_flush, MEM_WB_bubble, mem_err, state,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_memread, EX_rd,
           EX_branch_taken, MEM_memread, MEM_memwrite, mem_ready,
    output mem_req, pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
           IF_ID_flush, ID_EX_flush, MEM_WB_bubble, mem_err, state,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: stage write enables, flush/bubble controls,
// load-use stall, taken-branch flush, data-memory wait with timeout error,
// saturating stall/flush counters.
//   clk   : clock
//   rst_n : synchronous active-low reset (also forces safe outputs while low)
//   bus   : pipeline_ctrl_if.slave (status in, controls/counters out)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN  00  | normal issue; memory freeze > branch flush > load-use stall
// WAIT 10  | data memory not ready, pipeline frozen, MEM_WB bubbled
// ERR  11  | memory timed out; everything held until reset
// --   01  | unreachable, returns to RUN
module pipeline_ctrl #(
  parameter int REG_W       = 3,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input logic           clk,
  input logic           rst_n,
  pipeline_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_RUN    = 2'b00,
    S_UNUSED = 2'b01,
    S_WAIT   = 2'b10,
    S_ERR    = 2'b11
  } state_t;

  // Wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t           r_state;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             r_mem_err;

  logic w_req, w_not_ready, w_freeze, w_branch, w_hazard;
  logic w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
  logic w_if_id_flush, w_id_ex_flush, w_mem_wb_bubble;

  always_comb begin
    w_req           = 1'b0;
    w_freeze        = 1'b0;
    w_branch        = 1'b0;
    w_pc_en         = 1'b0;
    w_if_id_en      = 1'b0;
    w_id_ex_en      = 1'b0;
    w_ex_mem_en     = 1'b0;
    w_mem_wb_en     = 1'b0;
    w_if_id_flush   = 1'b0;
    w_id_ex_flush   = 1'b0;
    w_mem_wb_bubble = 1'b0;
    // x0 is hardwired zero, so a load targeting it never creates a hazard.
    w_hazard = bus.EX_memread && (bus.EX_rd != '0) &&
               ((bus.ID_use_rs1 && (bus.ID_rs1 == bus.EX_rd)) ||
                (bus.ID_use_rs2 && (bus.ID_rs2 == bus.EX_rd)));
    if (!rst_n) begin
      w_if_id_flush   = 1'b1;
      w_id_ex_flush   = 1'b1;
      w_mem_wb_bubble = 1'b1;
    end else begin
      case (r_state)
        S_RUN, S_WAIT: begin
          w_req = bus.MEM_memread | bus.MEM_memwrite;
          // In WAIT the freeze holds on mem_ready alone, even if the request drops.
          w_freeze = (r_state == S_WAIT) ? !bus.mem_ready : (w_req && !bus.mem_ready);
          if (w_freeze) begin
            w_mem_wb_en     = 1'b1;
            w_mem_wb_bubble = 1'b1;
          end else if ((r_state == S_RUN) && bus.EX_branch_taken) begin
            w_branch      = 1'b1;
            {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = '1;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
          end else if ((r_state == S_RUN) && w_hazard) begin
            w_id_ex_en    = 1'b1;
            w_id_ex_flush = 1'b1;
            w_ex_mem_en   = 1'b1;
            w_mem_wb_en   = 1'b1;
          end else begin
            {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = '1;
          end
        end
        default: ;
      endcase
    end
    w_not_ready = w_req && !bus.mem_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_wait      <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      case (r_state)
        S_RUN, S_WAIT: begin
          if (w_not_ready && (r_wait == WAIT_LAST)) begin
            r_state   <= S_ERR;
            r_wait    <= '0;
            r_mem_err <= 1'b1;
          end else begin
            r_wait  <= w_not_ready ? r_wait + 1'b1 : '0;
            r_state <= w_freeze ? S_WAIT : S_RUN;
          end
          if (!w_pc_en && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
          if (w_branch && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
        S_ERR: ;
        default: begin
          r_state <= S_RUN;
          r_wait  <= '0;
        end
      endcase
    end
  end

  assign bus.mem_req       = w_req;
  assign bus.pc_en         = w_pc_en;
  assign bus.IF_ID_en      = w_if_id_en;
  assign bus.ID_EX_en      = w_id_ex_en;
  assign bus.EX_MEM_en     = w_ex_mem_en;
  assign bus.MEM_WB_en     = w_mem_wb_en;
  assign bus.IF_ID_flush   = w_if_id_flush;
  assign bus.ID_EX_flush   = w_id_ex_flush;
  assign bus.MEM_WB_bubble = w_mem_wb_bubble;
  assign bus.mem_err       = r_mem_err;
  assign bus.state         = r_state;
  assign bus.stall_cnt     = r_stall_cnt;
  assign bus.flush_cnt     = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: a 16-bit-counter instance and a 4-bit-counter
// instance share the same stimulus; both are compared against a cycle model.
module tb_pipeline_ctrl;
  localparam int TO = 15;
  localparam int M_RUN = 0, M_WAIT = 2, M_ERR = 3;

  typedef struct {
    logic [2:0] rs1, rs2, exrd;
    logic use1, use2, exload, br, mrd, mwr, rdy;
  } in_t;

  typedef struct {
    logic [2:0] rs1, rs2;
    logic use1, use2, exload;
    logic [2:0] exrd;
    logic br, mrd, mwr, rdy;
    logic [4:0] exp_en;
    logic [2:0] exp_fl;
    logic exp_req;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  cur;
  int   errors = 0;
  int   checks = 0;

  int   m_mode = M_RUN;
  int   m_wait = 0;
  int   m_stall = 0;
  int   m_flush = 0;
  bit   m_known = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.REG_W(3), .CNT_W(16)) bus_a ();
  pipeline_ctrl_if #(.REG_W(3), .CNT_W(4))  bus_b ();

  pipeline_ctrl #(.REG_W(3), .CNT_W(16), .MEM_TIMEOUT(TO)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  pipeline_ctrl #(.REG_W(3), .CNT_W(4),  .MEM_TIMEOUT(TO)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  always_comb begin
    bus_a.ID_rs1 = cur.rs1;           bus_b.ID_rs1 = cur.rs1;
    bus_a.ID_rs2 = cur.rs2;           bus_b.ID_rs2 = cur.rs2;
    bus_a.ID_use_rs1 = cur.use1;      bus_b.ID_use_rs1 = cur.use1;
    bus_a.ID_use_rs2 = cur.use2;      bus_b.ID_use_rs2 = cur.use2;
    bus_a.EX_memread = cur.exload;    bus_b.EX_memread = cur.exload;
    bus_a.EX_rd = cur.exrd;           bus_b.EX_rd = cur.exrd;
    bus_a.EX_branch_taken = cur.br;   bus_b.EX_branch_taken = cur.br;
    bus_a.MEM_memread = cur.mrd;      bus_b.MEM_memread = cur.mrd;
    bus_a.MEM_memwrite = cur.mwr;     bus_b.MEM_memwrite = cur.mwr;
    bus_a.mem_ready = cur.rdy;        bus_b.mem_ready = cur.rdy;
  end

  wire [4:0] a_en = {bus_a.pc_en, bus_a.IF_ID_en, bus_a.ID_EX_en, bus_a.EX_MEM_en, bus_a.MEM_WB_en};
  wire [4:0] b_en = {bus_b.pc_en, bus_b.IF_ID_en, bus_b.ID_EX_en, bus_b.EX_MEM_en, bus_b.MEM_WB_en};
  wire [2:0] a_fl = {bus_a.IF_ID_flush, bus_a.ID_EX_flush, bus_a.MEM_WB_bubble};
  wire [2:0] b_fl = {bus_b.IF_ID_flush, bus_b.ID_EX_flush, bus_b.MEM_WB_bubble};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int w);
    int lim = (1 << w) - 1;
    return (n > lim) ? lim : n;
  endfunction

  task automatic clear_inputs();
    cur = '{default: '0};
  endtask

  // Called shortly after the negedge with inputs applied: checks this cycle
  // against the model, advances the model across the coming posedge, and
  // returns at the next negedge.
  task automatic tick(input string tag);
    logic [4:0] en;
    logic [2:0] fl;
    logic req, frz, br, lu, nrdy;
    #1;
    en = '0; fl = '0; req = 0; frz = 0; br = 0;
    lu = cur.exload && (cur.exrd != 0) &&
         ((cur.use1 && cur.rs1 == cur.exrd) || (cur.use2 && cur.rs2 == cur.exrd));
    if (!rst_n) fl = 3'b111;
    else if (m_mode != M_ERR) begin
      req = cur.mrd | cur.mwr;
      frz = (m_mode == M_RUN) ? (req && !cur.rdy) : !cur.rdy;
      if (frz)                  begin en = 5'b00001; fl = 3'b001; end
      else if (m_mode == M_WAIT) en = 5'b11111;
      else if (cur.br)          begin en = 5'b11111; fl = 3'b110; br = 1; end
      else if (lu)              begin en = 5'b00111; fl = 3'b010; end
      else                      en = 5'b11111;
    end
    chk({tag, ".en"}, {27'b0, a_en}, {27'b0, en});
    chk({tag, ".fl"}, {29'b0, a_fl}, {29'b0, fl});
    chk({tag, ".req"}, {31'b0, bus_a.mem_req}, {31'b0, req});
    chk({tag, ".b_ctl"}, {23'b0, b_en, b_fl, bus_b.mem_req}, {23'b0, en, fl, req});
    if (m_known) begin
      chk({tag, ".state"}, {30'b0, bus_a.state}, m_mode);
      chk({tag, ".err"}, {31'b0, bus_a.mem_err}, (m_mode == M_ERR) ? 1 : 0);
      chk({tag, ".stall"}, {16'b0, bus_a.stall_cnt}, sat(m_stall, 16));
      chk({tag, ".flush"}, {16'b0, bus_a.flush_cnt}, sat(m_flush, 16));
      chk({tag, ".stall4"}, {28'b0, bus_b.stall_cnt}, sat(m_stall, 4));
      chk({tag, ".flush4"}, {28'b0, bus_b.flush_cnt}, sat(m_flush, 4));
    end
    if (!rst_n) begin
      m_mode = M_RUN; m_wait = 0; m_stall = 0; m_flush = 0; m_known = 1;
    end else if (m_mode != M_ERR) begin
      nrdy = req && !cur.rdy;
      if (!en[4]) m_stall++;
      if (br) m_flush++;
      if (nrdy && m_wait == TO - 1) m_mode = M_ERR;
      else begin
        m_wait = nrdy ? m_wait + 1 : 0;
        m_mode = frz ? M_WAIT : M_RUN;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    clear_inputs();
    for (int i = 0; i < n; i++) tick("rst");
    rst_n = 1'b1;
  endtask

  vec_t vt[$];
  int   s0, slow;

  initial begin
    clear_inputs();
    @(negedge clk);

    // reset held 3 cycles, then release
    do_reset(3);
    #1;
    chk("rst.state", {30'b0, bus_a.state}, 0);
    chk("rst.cnt", {bus_a.stall_cnt, bus_a.flush_cnt}, 0);
    chk("rel.en", {27'b0, a_en}, 32'h1f);
    tick("rel");

    // load-use on rs2, exactly one stall cycle
    cur.exload = 1; cur.exrd = 3; cur.rs2 = 3; cur.use2 = 1;
    tick("lu");
    clear_inputs();
    #1;
    chk("lu.after_pc_en", {31'b0, bus_a.pc_en}, 1);
    chk("lu.stall_cnt", {16'b0, bus_a.stall_cnt}, 1);
    tick("lu2");
    cur.exload = 1; cur.exrd = 0; cur.rs2 = 0; cur.use2 = 1;
    #1;
    chk("lu_x0.pc_en", {31'b0, bus_a.pc_en}, 1);
    tick("lu_x0");

    // branch together with a load-use match
    cur.exload = 1; cur.exrd = 3; cur.rs1 = 3; cur.use1 = 1; cur.br = 1;
    #1;
    chk("br.pc_en", {31'b0, bus_a.pc_en}, 1);
    tick("br");
    clear_inputs();
    #1;
    chk("br.flush_cnt", {16'b0, bus_a.flush_cnt}, 1);
    chk("br.stall_cnt", {16'b0, bus_a.stall_cnt}, 1);

    // memory wait of 4 cycles
    s0 = m_stall;
    cur.mrd = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mw.bubble", {31'b0, bus_a.MEM_WB_bubble}, 1);
      tick("mw");
      #1;
      chk("mw.state", {30'b0, bus_a.state}, 2);
    end
    cur.rdy = 1;
    tick("mw_rdy");
    clear_inputs();
    #1;
    chk("mw.run", {30'b0, bus_a.state}, 0);
    chk("mw.stall_delta", {16'b0, bus_a.stall_cnt}, s0 + 4);
    tick("mw_end");

    // timeout to ERR
    cur.mwr = 1;
    for (int i = 0; i < TO; i++) tick("to");
    #1;
    chk("to.state", {30'b0, bus_a.state}, 3);
    chk("to.err", {31'b0, bus_a.mem_err}, 1);
    cur.rdy = 1;
    tick("to_rdy");
    #1;
    chk("to.hold", {30'b0, bus_a.state}, 3);
    do_reset(1);
    #1;
    chk("to.rst_state", {30'b0, bus_a.state}, 0);
    chk("to.rst_err", {31'b0, bus_a.mem_err}, 0);
    tick("to_post");

    // 20 load-use stalls: 4-bit counter sticks at 15
    do_reset(1);
    cur.exload = 1; cur.exrd = 5; cur.rs1 = 5; cur.use1 = 1;
    for (int i = 0; i < 20; i++) tick("sat");
    #1;
    chk("sat.stall4", {28'b0, bus_b.stall_cnt}, 15);
    chk("sat.stall16", {16'b0, bus_a.stall_cnt}, 20);
    clear_inputs();
    tick("sat_end");

    // RUN-state decision table
    vt.push_back('{0,0,0,0,0,0,0,0,0,0, 5'b11111, 3'b000, 0});
    vt.push_back('{5,0,1,0,1,5,0,0,0,0, 5'b00111, 3'b010, 0});
    vt.push_back('{0,3,0,1,1,3,0,0,0,0, 5'b00111, 3'b010, 0});
    vt.push_back('{5,5,0,0,1,5,0,0,0,0, 5'b11111, 3'b000, 0});
    vt.push_back('{0,0,1,1,1,0,0,0,0,0, 5'b11111, 3'b000, 0});
    vt.push_back('{2,2,1,1,0,2,0,0,0,0, 5'b11111, 3'b000, 0});
    vt.push_back('{0,0,0,0,0,0,1,0,0,0, 5'b11111, 3'b110, 0});
    vt.push_back('{4,0,1,0,1,4,1,0,0,0, 5'b11111, 3'b110, 0});
    vt.push_back('{0,0,0,0,0,0,0,1,0,1, 5'b11111, 3'b000, 1});
    vt.push_back('{1,6,0,1,1,6,0,0,1,1, 5'b00111, 3'b010, 1});
    vt.push_back('{0,0,0,0,0,0,1,0,1,1, 5'b11111, 3'b110, 1});
    vt.push_back('{7,7,1,1,1,7,0,1,1,1, 5'b00111, 3'b010, 1});
    foreach (vt[k]) begin
      cur.rs1 = vt[k].rs1; cur.rs2 = vt[k].rs2; cur.use1 = vt[k].use1; cur.use2 = vt[k].use2;
      cur.exload = vt[k].exload; cur.exrd = vt[k].exrd; cur.br = vt[k].br;
      cur.mrd = vt[k].mrd; cur.mwr = vt[k].mwr; cur.rdy = vt[k].rdy;
      #1;
      chk($sformatf("vec%0d.ctl", k), {23'b0, a_en, a_fl, bus_a.mem_req},
          {23'b0, vt[k].exp_en, vt[k].exp_fl, vt[k].exp_req});
      tick($sformatf("vec%0d", k));
    end

    // randomized traffic against the model
    slow = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) slow = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      cur.rs1 = 3'($urandom_range(0, 3));
      cur.rs2 = 3'($urandom_range(0, 3));
      cur.exrd = 3'($urandom_range(0, 3));
      cur.use1 = 1'($urandom);
      cur.use2 = 1'($urandom);
      cur.exload = 1'($urandom);
      cur.br = ($urandom_range(0, 7) == 0);
      cur.mrd = ($urandom_range(0, 3) == 0);
      cur.mwr = ($urandom_range(0, 5) == 0);
      cur.rdy = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0);
      tick("rnd");
    end
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline sequencing controller for the 5-stage CPU. Generates the per-stage write enables and flush/bubble controls for the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers. Handles:
- load-use hazard stalls;
- taken-branch flushes;
- variable-latency data-memory handshakes, with a timeout error state.

Also keeps saturating stall and flush performance counters.

## Interface
- `REG_W`, 3, register index width
- `CNT_W`, 16, performance counter width
- `MEM_TIMEOUT`, 15, consecutive not-ready cycles before error (≥2)

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `ID_rs1`, `ID_rs2`  in  REG_W  source registers of instruction in ID
- `ID_use_rs1`, `ID_use_rs2`  in  1  source actually read
- `EX_memread`  in  1  instruction in EX is a load
- `EX_rd`  in  REG_W  destination of instruction in EX
- `EX_branch_taken`  in  1  branch resolved taken in EX
- `MEM_memread`, `MEM_memwrite`  in  1  MEM-stage memory op
- `mem_ready`  in  1  data memory completes access this cycle
- `mem_req`  out  1  data memory request
- `pc_en`, `IF_ID_en`, `ID_EX_en`, `EX_MEM_en`, `MEM_WB_en`  out  1  stage register write enables
- `IF_ID_flush`, `ID_EX_flush`, `MEM_WB_bubble`  out  1  load NOP/zero controls into that register
- `mem_err`  out  1  sticky memory timeout flag
- `state`  out  2  FSM state
- `stall_cnt`, `flush_cnt`  out  CNT_W  saturating counters

## Operation
States: RUN=00, MEM_WAIT=10, ERR=11. Encoding 01 is unused and recovers to RUN.

Reset (`rst_n`=0 at edge):
- `state`=RUN, counters=0, `mem_err`=0, wait counter=0.
- Outputs are combinational on `rst_n` while it is low: all `_en`=0, `IF_ID_flush`=`ID_EX_flush`=`MEM_WB_bubble`=1, `mem_req`=0.

`mem_req` = `MEM_memread` | `MEM_memwrite` in RUN and MEM_WAIT; 0 in ERR.

RUN decisions, highest priority first:
1. **Memory not ready** (`mem_req` & !`mem_ready`): freeze. All `_en`=0 except `MEM_WB_en`=1 with `MEM_WB_bubble`=1. Next state MEM_WAIT.
2. **Branch taken** (`EX_branch_taken`): all `_en`=1, `IF_ID_flush`=1, `ID_EX_flush`=1. `flush_cnt`++.
3. **Load-use hazard**: `EX_memread` & `EX_rd`≠0 & ((`ID_use_rs1` & `ID_rs1`==`EX_rd`) | (`ID_use_rs2` & `ID_rs2`==`EX_rd`)).
   - `pc_en`=`IF_ID_en`=0.
   - `ID_EX_en`=1 with `ID_EX_flush`=1 (bubble).
   - `EX_MEM_en`=`MEM_WB_en`=1.
   - Exactly one cycle; clears naturally after the bubble enters EX.
4. **Otherwise**: all `_en`=1, no flush/bubble.

Register 0 is hardwired zero and never causes a hazard.

MEM_WAIT:
- Freeze outputs as in RUN case 1 while !`mem_ready`.
- On `mem_ready`=1: all `_en`=1, no bubble, next state RUN.
- Branch and load-use are not evaluated in MEM_WAIT. EX is frozen, so they re-evaluate on the first RUN cycle.

Wait counter:
- Increments each cycle with `mem_req` & !`mem_ready`; cleared when `mem_ready`=1 or `mem_req`=0.
- If not-ready persists for MEM_TIMEOUT consecutive cycles (counter == MEM_TIMEOUT−1 and still not ready), next state is ERR.

ERR:
- All `_en`=0, flushes 0, `mem_req`=0, `mem_err`=1.
- Held until reset; all inputs ignored.

Counters:
- `stall_cnt`++ on every RUN/MEM_WAIT cycle with `pc_en`=0.
- Both counters saturate at all-ones. They are not incremented in ERR or reset.

## Timing
- All enables and flushes are combinational from current state and inputs, valid in the same cycle. The state register updates at the next edge.
- A load-use stall costs 1 cycle. A branch costs 2 flushed slots, with 0 extra cycles.
- A memory access with `mem_ready` in the same cycle as `mem_req` costs 0 stall cycles. Otherwise it costs N stall cycles, where `mem_ready` arrives N cycles after `mem_req` rises.
- Memory not-ready with a simultaneous branch: the freeze wins, and the branch is applied in the cycle `mem_ready` returns in MEM_WAIT + 1 (the first RUN cycle).
- Memory not-ready with a simultaneous load-use hazard: the freeze wins, and no bubble enters ID_EX.
- Reset asserted mid-MEM_WAIT or in ERR: RUN after the edge, `mem_err` cleared.

## Test plan
- **Reset**: hold `rst_n`=0 for 3 cycles → all `_en`=0, all flushes=1, `state`=00, counters=0, `mem_req`=0. Release → all `_en`=1.
- **Load-use**: `EX_memread`=1, `EX_rd`=3, `ID_rs2`=3, `ID_use_rs2`=1 for one cycle → `pc_en`=`IF_ID_en`=0 and `ID_EX_flush`=1 for exactly 1 cycle; `stall_cnt`=1. Repeat with `EX_rd`=0 → no stall.
- **Branch with hazard**: `EX_branch_taken`=1 together with a load-use match → `IF_ID_flush`=`ID_EX_flush`=1, `pc_en`=1; `flush_cnt`=1, `stall_cnt` unchanged.
- **Memory wait**: `MEM_memread`=1, `mem_ready` low for 4 cycles then high → `state`=10 for 4 cycles, `MEM_WB_bubble`=1 for 4 cycles, `stall_cnt`+=4, RUN on the 5th cycle.
- **Timeout**: `MEM_memwrite`=1, `mem_ready`=0 for 15 cycles → `state`=11 and `mem_err`=1 from cycle 16. Further `mem_ready`=1 has no effect. `rst_n` pulse → RUN, `mem_err`=0.
- **Saturation**: `CNT_W`=4, 20 load-use stalls → `stall_cnt`=15 and holds.
